// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Timed channel scanner for an 8:1 mux stage. A start request steps the
// select lines through channels 0..7. Each channel is held for DWELL cycles.
// The mux output is sampled at the end of each dwell. The eight samples are
// then published together as one word, with a single-cycle done pulse.
//
// Parameters:
//   DWELL    cycles each channel stays selected before sampling (1..255)
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   i_start  scan request, honoured only when idle (see MUX_SCAN_CONT_EN)
//   i_y      mux output, must settle within one cycle of a select change
//   o_s1     select bit 2 (MSB)
//   o_s2     select bit 1
//   o_s3     select bit 0 (LSB)
//   o_busy   high while a scan is in progress
//   o_done   one-cycle pulse when o_word updates
//   o_word   last completed scan, bit k = sample of channel k
// Build option:
//   MUX_SCAN_CONT_EN  when defined, a start seen in DONE restarts the scan
//                     immediately with no idle gap between scans.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_y,
  output logic       o_s1,
  output logic       o_s2,
  output logic       o_s3,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_word
);

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_sel;
  logic [2:0] w_sel_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] r_stage;
  logic [7:0] w_stage_nxt;
  logic [7:0] r_word;
  logic [7:0] w_word_nxt;
  logic       w_done_nxt;
  logic       r_busy;
  logic       r_done;

  // Next-state, next-register and output-update logic for the scan sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_word_nxt  = r_word;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_SCAN;
          w_sel_nxt   = 3'd0;
          w_cnt_nxt   = 8'd0;
          w_stage_nxt = 8'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (r_cnt == CNT_LAST) begin
          w_stage_nxt[r_sel] = i_y;
          w_cnt_nxt          = 8'd0;
          // sel never wraps: it parks on 7 until the next start clears it
          if (r_sel == 3'd7) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_sel_nxt = r_sel + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        // word and done are registered here, so both change on the
        // edge that leaves DONE
        w_word_nxt = r_stage;
        w_done_nxt = 1'b1;
`ifdef MUX_SCAN_CONT_EN
        if (i_start) begin
          w_state_nxt = ST_SCAN;
          w_sel_nxt   = 3'd0;
          w_cnt_nxt   = 8'd0;
          w_stage_nxt = 8'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 3'd0;
      r_cnt   <= 8'd0;
      r_stage <= 8'd0;
      r_word  <= 8'd0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
      r_word  <= w_word_nxt;
      r_done  <= w_done_nxt;
      // busy follows the state being entered, so it rises on the start edge
      // and falls on the edge that leaves DONE
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_s1   = r_sel[2];
  assign o_s2   = r_sel[1];
  assign o_s3   = r_sel[0];
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_word = r_word;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl. Two instances are used: DWELL=2 (u0) and
// DWELL=1 (u1). Each one drives a modelled 8:1 mux whose inputs are held in
// mux_v[i]. A timeline model predicts sel/busy/done/word every cycle from
// the start edge and the dwell arithmetic. A table and several hand-written
// sequences cover the named corner cases.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic [1:0] rst_v;
  logic [1:0] start_v;
  logic [7:0] mux_v [2];
  wire  [1:0] y_v;
  wire  [1:0] s1_v;
  wire  [1:0] s2_v;
  wire  [1:0] s3_v;
  wire  [1:0] busy_v;
  wire  [1:0] done_v;
  wire  [7:0] word_v [2];

  always #5 clk = ~clk;

  assign y_v[0] = mux_v[0][{s1_v[0], s2_v[0], s3_v[0]}];
  assign y_v[1] = mux_v[1][{s1_v[1], s2_v[1], s3_v[1]}];

  mux_scan_ctrl #(.DWELL(2)) u0 (
    .i_clk(clk), .i_rst(rst_v[0]), .i_start(start_v[0]), .i_y(y_v[0]),
    .o_s1(s1_v[0]), .o_s2(s2_v[0]), .o_s3(s3_v[0]),
    .o_busy(busy_v[0]), .o_done(done_v[0]), .o_word(word_v[0])
  );

  mux_scan_ctrl #(.DWELL(1)) u1 (
    .i_clk(clk), .i_rst(rst_v[1]), .i_start(start_v[1]), .i_y(y_v[1]),
    .o_s1(s1_v[1]), .o_s2(s2_v[1]), .o_s3(s3_v[1]),
    .o_busy(busy_v[1]), .o_done(done_v[1]), .o_word(word_v[1])
  );

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: timeline of one scan ----------------
  int         dw [2] = '{2, 1};
  int         e_cnt [2];
  bit         act [2];
  int         t0 [2];
  int         idle_from [2];
  logic [7:0] samp [2];
  logic [7:0] exp_word [2];
  bit         exp_done [2];
  bit         exp_busy [2];
  int         exp_sel [2];

  function automatic void model_reset(input int i);
    e_cnt[i] = 0; act[i] = 1'b0; t0[i] = 0; idle_from[i] = 0;
    samp[i] = 8'h00; exp_word[i] = 8'h00; exp_done[i] = 1'b0;
    exp_busy[i] = 1'b0; exp_sel[i] = 0;
  endfunction

  function automatic void model_edge(input int i, input logic st, input logic [7:0] mx);
    int rel;
    int k;
    e_cnt[i]++;
    exp_done[i] = 1'b0;
    if (act[i]) begin
      rel = e_cnt[i] - t0[i];
      // channel k is sampled on edge t0 + (k+1)*DWELL
      if (rel >= 1 && rel <= 8 * dw[i] && (rel % dw[i]) == 0) begin
        k = rel / dw[i] - 1;
        samp[i][k[2:0]] = mx[k[2:0]];
      end
      if (rel == 8 * dw[i] + 1) begin
        exp_done[i]  = 1'b1;
        exp_word[i]  = samp[i];
        act[i]       = 1'b0;
        idle_from[i] = e_cnt[i] + 1;
`ifdef MUX_SCAN_CONT_EN
        if (st) begin
          act[i] = 1'b1; t0[i] = e_cnt[i]; samp[i] = 8'h00;
        end
`endif
      end
    end else if (st && e_cnt[i] >= idle_from[i]) begin
      act[i] = 1'b1; t0[i] = e_cnt[i]; samp[i] = 8'h00;
    end
    exp_busy[i] = act[i];
    if (act[i]) exp_sel[i] = ((e_cnt[i] - t0[i]) / dw[i] > 7) ? 7 : (e_cnt[i] - t0[i]) / dw[i];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i]) model_reset(i);
      else model_edge(i, start_v[i], mux_v[i]);
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d_sel", i), 32'({s1_v[i], s2_v[i], s3_v[i]}), 32'(exp_sel[i]));
        check($sformatf("u%0d_busy", i), 32'(busy_v[i]), 32'(exp_busy[i]));
        check($sformatf("u%0d_done", i), 32'(done_v[i]), 32'(exp_done[i]));
        check($sformatf("u%0d_word", i), 32'(word_v[i]), 32'(exp_word[i]));
      end
    end
  end

  // pulse start for one cycle, then wait (bounded) for done
  task automatic run_scan(input int i, output int lat, output logic [7:0] w, output bit seen);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    lat = 0; seen = 1'b0; w = 8'h00;
    while (!seen && lat < 100) begin
      if (done_v[i]) begin
        seen = 1'b1; w = word_v[i];
      end else begin
        @(negedge clk); lat++;
      end
    end
  endtask

  typedef struct {
    int         inst;
    logic [7:0] mux;
    logic [7:0] word;
    int         lat;
  } vec_t;

  vec_t       vecs [8];
  int         lat;
  logic [7:0] w;
  bit         seen;
  int         d1, d2, nlow, ndone, dlat;

  initial begin
    vecs[0] = '{0, 8'h55, 8'h55, 17};
    vecs[1] = '{0, 8'hAA, 8'hAA, 17};
    vecs[2] = '{0, 8'h00, 8'h00, 17};
    vecs[3] = '{0, 8'hFF, 8'hFF, 17};
    vecs[4] = '{1, 8'h81, 8'h81, 9};
    vecs[5] = '{1, 8'h3C, 8'h3C, 9};
    vecs[6] = '{0, 8'h96, 8'h96, 17};
    vecs[7] = '{1, 8'h01, 8'h01, 9};

    rst_v = 2'b00; start_v = 2'b00; mux_v[0] = 8'h00; mux_v[1] = 8'h00;
    #1 rst_v = 2'b11;
    model_reset(0); model_reset(1);
    @(negedge clk); @(negedge clk);
    rst_v = 2'b00;
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", 32'(busy_v[i]), 32'd0);
      check("reset_word", 32'(word_v[i]), 32'h00);
      check("reset_sel", 32'({s1_v[i], s2_v[i], s3_v[i]}), 32'd0);
    end

    // table-driven scans
    for (int v = 0; v < 8; v++) begin
      mux_v[vecs[v].inst] = vecs[v].mux;
      run_scan(vecs[v].inst, lat, w, seen);
      check($sformatf("vec%0d_done_seen", v), 32'(seen), 32'd1);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      check($sformatf("vec%0d_word", v), 32'(w), 32'(vecs[v].word));
      @(negedge clk);
    end

    // start toggled while busy on DWELL=1: exactly one scan
    mux_v[1] = 8'hAA; start_v[1] = 1'b1; ndone = 0; dlat = -1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (done_v[1]) begin ndone++; dlat = n - 1; end
      start_v[1] = (n < 7) ? ~start_v[1] : 1'b0;
    end
    check("ignored_start_ndone", 32'(ndone), 32'd1);
    check("ignored_start_latency", 32'(dlat), 32'd9);
    check("ignored_start_word", 32'(word_v[1]), 32'hAA);

    // async reset mid-scan during channel 3
    mux_v[0] = 8'h55; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if ({s1_v[0], s2_v[0], s3_v[0]} == 3'd3) break;
      @(negedge clk);
    end
    check("pre_reset_sel3", 32'({s1_v[0], s2_v[0], s3_v[0]}), 32'd3);
    #2 rst_v[0] = 1'b1;
    model_reset(0);
    #1;
    check("async_rst_busy", 32'(busy_v[0]), 32'd0);
    check("async_rst_sel", 32'({s1_v[0], s2_v[0], s3_v[0]}), 32'd0);
    check("async_rst_word", 32'(word_v[0]), 32'h00);
    @(negedge clk);
    rst_v[0] = 1'b0;
    run_scan(0, lat, w, seen);
    check("post_reset_latency", 32'(lat), 32'd17);
    check("post_reset_word", 32'(w), 32'h55);
    @(negedge clk);

    // live input: i5 rises after channel 5 has been sampled
    mux_v[0] = 8'h00; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int n = 0; n < 12; n++) @(negedge clk);
    mux_v[0][5] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (done_v[0]) break;
      @(negedge clk);
    end
    check("live_first_done", 32'(done_v[0]), 32'd1);
    check("live_first_word", 32'(word_v[0]), 32'h00);
    @(negedge clk);
    run_scan(0, lat, w, seen);
    check("live_second_word", 32'(w), 32'h20);
    @(negedge clk);

    // start held high: back-to-back period and busy gap
    mux_v[0] = 8'h33; start_v[0] = 1'b1; d1 = -1; d2 = -1; nlow = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (done_v[0]) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (d1 >= 0 && d2 < 0 && !busy_v[0]) nlow++;
    end
    start_v[0] = 1'b0;
`ifdef MUX_SCAN_CONT_EN
    check("hold_start_period", 32'(d2 - d1), 32'd17);
    check("hold_start_busy_low", 32'(nlow), 32'd0);
`else
    check("hold_start_period", 32'(d2 - d1), 32'd18);
    check("hold_start_busy_low", 32'(nlow), 32'd1);
`endif
    check("hold_start_word", 32'(word_v[0]), 32'h33);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy_v[0] && !busy_v[1]) break;
    end

    // randomized traffic on both instances, checked by the model
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) mux_v[i] = 8'($urandom);
        start_v[i] = ($urandom_range(0, 4) == 0);
      end
    end
    start_v = 2'b00;
    for (int n = 0; n < 40; n++) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
